// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic IF->ID pipeline register.
// Holds the RV32 bubble encoding and the occupancy state type.
// State encoding is {skid_valid, main_valid}, so the valid bits read directly off the state.
`timescale 1ns/1ps
package pipe_pkg;

  // addi x0, x0, 0: the canonical RV32 NOP presented downstream as a bubble.
  localparam logic [31:0] NOP_INST_RV32 = 32'h00000013;

  // The encoding doubles as {skid_valid, main_valid}.
  // 2'b10 (skid without main) is illegal.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline register carrying {inst, pc}, with optional 2-entry skid, flush-to-NOP and a flush-kill counter.
// Latency: 1 cycle from an accepted beat in EMPTY to out_valid; 1 beat/cycle sustained while out_ready=1.
// Backpressure: SKID=1 registers in_ready (low only when the skid entry is held); SKID=0 passes out_ready through combinationally.
//
// Ports:
//   clk, nrst                     clock and synchronous active-low reset
//   flush                         drop every held entry plus the incoming beat this cycle
//   in_valid/in_ready/in_inst/in_pc      upstream handshake and payload
//   out_valid/out_ready/out_inst/out_pc  downstream handshake and payload (NOP/0 when no valid beat)
//   occupancy                     number of held entries (0..2)
//   kill_cnt                      saturating count of valid entries discarded by flush
`timescale 1ns/1ps
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 INST_W   = 32,
  parameter int                 PC_W     = 32,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_RV32),
  parameter int                 SKID     = 1,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  kill_cnt
);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } payload_t;

  // Value parked in an empty slot, so a stale payload never lingers in the registers.
  localparam payload_t BUBBLE = {NOP_INST, {PC_W{1'b0}}};

  pipe_state_e      state_q, state_d;
  payload_t         main_q, main_d;
  payload_t         skid_q, skid_d;
  logic [CNT_W-1:0] kill_q, kill_d;
  logic [CNT_W:0]   kill_sum;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  // Handshakes are suppressed while nrst is low, so nothing is accepted or presented during reset.
  // A flush cycle never transfers downstream, even when out_ready is high.
  assign out_valid = main_valid & ~flush & nrst;

  generate
    if (SKID != 0) begin : g_skid
      // Only registered state feeds in_ready, which breaks the ready path back from downstream.
      assign in_ready = ~skid_valid & ~flush & nrst;
    end else begin : g_single
      assign in_ready = (~main_valid | out_ready) & ~flush & nrst;
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // The bubble is shown whenever no beat is presented, including during the flush cycle itself.
  assign out_inst  = out_valid ? main_q.inst : NOP_INST;
  assign out_pc    = out_valid ? main_q.pc   : '0;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign kill_cnt  = kill_q;

  // One guard bit catches overflow. The increment is at most 2,
  // so any overflow saturates to all-ones.
  assign kill_sum = {1'b0, kill_q} + {{(CNT_W-1){1'b0}}, occupancy};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    kill_d  = kill_q;

    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
      kill_d  = kill_sum[CNT_W] ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = payload_t'({in_inst, in_pc});
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = payload_t'({in_inst, in_pc});
          end else if (in_fire && (SKID != 0)) begin
            // The head is still stalled, so the new beat parks behind it to keep FIFO order.
            state_d = FULL;
            skid_d  = payload_t'({in_inst, in_pc});
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end
        end
        FULL: begin
          // in_ready is low here, so the only possible event is the head leaving.
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      kill_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
`timescale 1ns/1ps
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // Instance A: skid enabled, narrow counter so saturation is reachable quickly.
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_inst, a_in_pc, a_out_inst, a_out_pc;
  logic [1:0]  a_occ;
  logic [7:0]  a_kill;
  // Instance B: single entry, default counter width.
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_inst, b_in_pc, b_out_inst, b_out_pc;
  logic [1:0]  b_occ;
  logic [15:0] b_kill;

  pipe_skid_reg #(.SKID(1), .CNT_W(8)) dut_a (
    .clk(clk), .nrst(nrst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inst(a_out_inst), .out_pc(a_out_pc),
    .occupancy(a_occ), .kill_cnt(a_kill)
  );

  pipe_skid_reg #(.SKID(0)) dut_b (
    .clk(clk), .nrst(nrst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inst(b_out_inst), .out_pc(b_out_pc),
    .occupancy(b_occ), .kill_cnt(b_kill)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, an ordered queue of accepted beats plus a kill tally.
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int          kill_m[2];

  task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h at %0t", d, nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic logic [63:0] qfront(input int d);
    if (d == 0) return (qa.size() > 0) ? qa[0] : 64'd0;
    return (qb.size() > 0) ? qb[0] : 64'd0;
  endfunction

  task automatic qpush(input int d, input logic [63:0] v);
    if (d == 0) qa.push_back(v); else qb.push_back(v);
  endtask

  task automatic qpop(input int d);
    if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
  endtask

  task automatic qclear(input int d);
    if (d == 0) qa.delete(); else qb.delete();
  endtask

  // Compares one instance against the model for the current cycle, then advances the model
  // by the transfers that the rules say happen at the coming edge.
  task automatic check_dut(input int d, input bit skid, input int maxk, input logic rst_n,
                           input logic fl, input logic ivld, input logic [31:0] iinst, input logic [31:0] ipc,
                           input logic ordy, input logic irdy, input logic ovld,
                           input logic [31:0] oinst, input logic [31:0] opc,
                           input logic [1:0] occ, input int kcnt);
    int  sz;
    bit  exp_ovld, exp_irdy;
    if (!rst_n) begin
      chk(d, "rst_in_ready",  64'(irdy),  64'd0);
      chk(d, "rst_out_valid", 64'(ovld),  64'd0);
      chk(d, "rst_out_inst",  64'(oinst), 64'(NOP_INST_RV32));
      chk(d, "rst_out_pc",    64'(opc),   64'd0);
      qclear(d);
      kill_m[d] = 0;
      return;
    end
    sz       = qsize(d);
    exp_ovld = (sz > 0) && !fl;
    exp_irdy = skid ? ((sz < 2) && !fl) : (((sz == 0) || ordy) && !fl);
    chk(d, "occupancy", 64'(occ),  64'(sz));
    chk(d, "kill_cnt",  64'(kcnt), 64'(kill_m[d]));
    chk(d, "out_valid", 64'(ovld), 64'(exp_ovld));
    chk(d, "in_ready",  64'(irdy), 64'(exp_irdy));
    if (exp_ovld) chk(d, "out_payload", {oinst, opc}, qfront(d));
    else          chk(d, "bubble", {oinst, opc}, {NOP_INST_RV32, 32'd0});
    if (fl) begin
      kill_m[d] = (kill_m[d] + sz > maxk) ? maxk : kill_m[d] + sz;
      qclear(d);
    end else begin
      if (exp_ovld && ordy) qpop(d);
      if (ivld && exp_irdy) qpush(d, {iinst, ipc});
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, 1'b1, 255, nrst, a_flush, a_in_valid, a_in_inst, a_in_pc, a_out_ready,
              a_in_ready, a_out_valid, a_out_inst, a_out_pc, a_occ, int'(a_kill));
    check_dut(1, 1'b0, 65535, nrst, b_flush, b_in_valid, b_in_inst, b_in_pc, b_out_ready,
              b_in_ready, b_out_valid, b_out_inst, b_out_pc, b_occ, int'(b_kill));
    if (nrst) chk(0, "skid_implies_main", 64'(!(dut_a.skid_valid && !dut_a.main_valid)), 64'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat and holds it until accepted, within a bounded number of cycles.
  task automatic send(input int d, input logic [31:0] inst, input logic [31:0] pc);
    logic acc;
    acc = 1'b0;
    if (d == 0) begin a_in_valid = 1'b1; a_in_inst = inst; a_in_pc = pc; end
    else        begin b_in_valid = 1'b1; b_in_inst = inst; b_in_pc = pc; end
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = (d == 0) ? a_in_ready : b_in_ready;
      tick();
    end
    if (d == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
    chk(d, "send_accepted", 64'(acc), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    nrst = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b1; a_in_inst = 32'hdead; a_in_pc = 32'h40; a_out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b1; b_in_inst = 32'hbeef; b_in_pc = 32'h80; b_out_ready = 1'b1;

    // Reset held for two edges with a beat offered.
    tick();
    tick();
    nrst = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk(0, "post_rst_kill", 64'(a_kill), 64'd0);
    chk(0, "post_rst_occ",  64'(a_occ),  64'd0);
    tick();

    // Back-to-back stream through A.
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1; a_in_inst = i; a_in_pc = 4 * i;
      tick();
    end
    a_in_valid = 1'b0;
    repeat (3) tick();

    // Fill A's skid with downstream stalled, then release and drain in order.
    a_out_ready = 1'b0;
    send(0, 32'h3000, 32'h100);
    send(0, 32'h3001, 32'h104);
    a_in_valid = 1'b1; a_in_inst = 32'h3002; a_in_pc = 32'h108;
    @(negedge clk);
    chk(0, "full_in_ready", 64'(a_in_ready), 64'd0);
    chk(0, "full_occ",      64'(a_occ),      64'd2);
    tick();
    a_out_ready = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) begin
      @(negedge clk);
      acc = a_in_ready;
      tick();
    end
    a_in_valid = 1'b0;
    chk(0, "third_beat_accepted", 64'(acc), 64'd1);
    repeat (4) tick();

    // Flush a full A while stalled and while a beat is offered.
    a_out_ready = 1'b0;
    send(0, 32'h4000, 32'h200);
    send(0, 32'h4001, 32'h204);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_inst = 32'h4002; a_in_pc = 32'h208;
    @(negedge clk);
    chk(0, "flush_in_ready",  64'(a_in_ready),  64'd0);
    chk(0, "flush_out_valid", 64'(a_out_valid), 64'd0);
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    chk(0, "after_flush_occ",  64'(a_occ),      64'd0);
    chk(0, "after_flush_inst", 64'(a_out_inst), 64'(NOP_INST_RV32));
    chk(0, "after_flush_pc",   64'(a_out_pc),   64'd0);
    chk(0, "after_flush_kill", 64'(a_kill),     64'd2);
    tick();

    // Saturation of the 8-bit kill counter: flush one held entry many times.
    for (int i = 0; i < 300; i++) begin
      send(0, $urandom, $urandom);
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
    end
    @(negedge clk);
    chk(0, "kill_saturated", 64'(a_kill), 64'd255);
    tick();
    send(0, 32'h5000, 32'h300);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    @(negedge clk);
    chk(0, "kill_no_wrap", 64'(a_kill), 64'd255);
    tick();
    a_out_ready = 1'b1;

    // Single-entry B: ready follows out_ready combinationally.
    b_out_ready = 1'b0;
    send(1, 32'h6000, 32'h400);
    b_in_valid = 1'b1; b_in_inst = 32'h6001; b_in_pc = 32'h404;
    @(negedge clk);
    chk(1, "stall_in_ready", 64'(b_in_ready), 64'd0);
    chk(1, "stall_occ",      64'(b_occ),      64'd1);
    tick();
    b_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b_in_inst = 32'h6010 + k; b_in_pc = 32'h500 + 4 * k;
      @(negedge clk);
      chk(1, "pass_in_ready",  64'(b_in_ready),  64'd1);
      chk(1, "pass_out_valid", 64'(b_out_valid), 64'd1);
      chk(1, "pass_occ",       64'(b_occ),       64'd1);
      tick();
    end
    b_in_valid = 1'b0;
    repeat (3) tick();

    // Random traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_flush     = ($urandom_range(0, 19) == 0);
      a_in_inst   = $urandom; a_in_pc = $urandom;
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush     = ($urandom_range(0, 19) == 0);
      b_in_inst   = $urandom; b_in_pc = $urandom;
      tick();
    end
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk(0, "drained", 64'(a_occ), 64'd0);
    chk(1, "drained", 64'(b_occ), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised, elastic successor to the fixed IF->ID pipeline register. It carries an instruction/PC payload between two pipeline stages using a valid/ready handshake instead of a bare stall. An optional 2-entry skid buffer cuts the combinational ready path, and it keeps flush-to-NOP semantics. A saturating counter records how many valid entries were killed by flush, for performance analysis.

Parameters:
INST_W, 32, instruction payload width
PC_W, 32, PC payload width
NOP_INST, 32'h00000013, bubble encoding driven on out_inst when no valid entry is presented (addi x0,x0,0)
SKID, 1, 1 = 2-entry skid (registered in_ready); 0 = single entry (in_ready combinational from out_ready)
CNT_W, 16, width of the flush-kill counter

Ports:
clk  in  1  clock, rising edge
nrst  in  1  synchronous active-low reset
flush  in  1  kill all held entries and the incoming beat this cycle
in_valid  in  1  upstream beat valid
in_ready  out  1  block accepts a beat this cycle
in_inst  in  INST_W  upstream instruction
in_pc  in  PC_W  upstream PC
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts (replaces legacy stall; stall == ~out_ready)
out_inst  out  INST_W  instruction of head entry, NOP_INST when not valid
out_pc  out  PC_W  PC of head entry, 0 when not valid
occupancy  out  2  entries held: 0, 1 or 2
kill_cnt  out  CNT_W  saturating count of valid entries discarded by flush

Behaviour:
- Decided interface: one clock clk; reset nrst is synchronous and active-low, sampled on posedge clk only.
- Reset: main_valid=0, skid_valid=0, out_inst=NOP_INST, out_pc=0, kill_cnt=0, occupancy=0. Reset overrides flush and all handshakes.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Payload is held stable while out_valid=1 and out_ready=0.
- out_valid = main_valid & ~flush. No downstream transfer occurs in a flush cycle.
- Readiness:
  - SKID=1: in_ready = ~skid_valid & ~flush.
  - SKID=0: in_ready = (~main_valid | out_ready) & ~flush.
- States, encoded by {skid_valid, main_valid}: EMPTY, ONE, FULL. FULL exists only when SKID=1.
  - EMPTY: in_fire -> ONE, main<=in. Otherwise hold.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in.
    - in_fire & ~out_fire -> FULL, skid<=in (SKID=1 only).
    - ~in_fire & out_fire -> EMPTY.
    - Neither -> hold.
  - FULL (in_ready=0):
    - out_fire -> ONE, main<=skid.
    - Otherwise hold.
- Latency: 1 cycle from in_fire in EMPTY to out_valid. Sustained throughput is 1 beat/cycle when out_ready=1.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Flush (highest priority below reset):
  - Next state EMPTY; out_inst<=NOP_INST; out_pc<=0.
  - The incoming beat is dropped (in_ready=0).
  - kill_cnt += main_valid + skid_valid, saturating at 2^CNT_W-1.
- Flush and out_ready=0 in the same cycle: flush wins. This differs from the legacy register, where stall won.
- When main_valid=0, out_inst/out_pc read NOP_INST/0 so that downstream decode sees a bubble.
- occupancy = main_valid + skid_valid.
- Invariant: skid_valid=1 implies main_valid=1. The bench asserts it.

Decomposition:
- pipe_pkg holds NOP_INST_RV32 = 32'h00000013 and a typedef pipe_state_e {EMPTY, ONE, FULL}.
- Payload is packed {inst, pc}.
- No sub-module. The counter is inline; a separate sat_counter would be too thin to justify.

Test Plan:
1. Reset with nrst=0 for 2 cycles, in_valid=1 -> out_valid=0, out_inst=32'h00000013, out_pc=0, in_ready=0 while nrst=0, kill_cnt=0.
2. Stream 8 beats (inst=i, pc=4*i) with out_ready=1 -> out_valid one cycle after each in_fire, same order, no gaps, occupancy stays 1.
3. SKID=1: out_ready=0 while sending beats pc=0x100, then 0x104, then 0x108 -> occupancy reaches 2, in_ready=0 on the 3rd beat. Raise out_ready -> 0x100, 0x104, 0x108 delivered in order.
4. FULL, then flush=1 with out_ready=0 -> next cycle occupancy=0, out_inst=NOP, out_pc=0, kill_cnt=2. A beat offered in the flush cycle is not accepted.
5. Flush 70000 times with 1 entry held, CNT_W=16 -> kill_cnt saturates at 65535 and does not wrap.
6. SKID=0: out_ready=0 with 1 entry held -> in_ready=0 in the same cycle. out_ready=1 and in_valid=1 -> simultaneous pass-through, occupancy stays 1.
